// File: rtl/pong_pkg.sv
// Shared types and constants for the pong joystick front end.
package pong_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } JOY_STATE_T;

    // 5 ms worth of cycles at a 25 MHz pixel clock.
    localparam int DEBOUNCE_5MS_25MHZ = 125000;

endpackage

// File: rtl/debounce_channel.sv
// One joystick pin: synchronizer, debounce FSM with saturating counter,
// registered active-low level and a one-cycle press pulse.
module debounce_channel
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_25MHZ,
    parameter int CNT_W           = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    JOY_STATE_T             state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Level and pulse are updated on the same edge as the state they reflect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                RELEASED: begin
                    if (!sync) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (sync) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        level <= 1'b0;
                        press <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (!sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                    level <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/joystick_conditioner.sv
// Two debounced joystick channels for one player.
// Optional macro JOY_CONFLICT_BLOCK_EN masks both outputs while both are pressed.
module joystick_conditioner
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_25MHZ,
    parameter int CNT_W           = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic joy_up_n,
    input  logic joy_down_n,
    output logic control_up,
    output logic control_down,
    output logic press_up,
    output logic press_down
);

    logic level_up;
    logic level_down;

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up (
        .clock(clock),
        .reset(reset),
        .pin_n(joy_up_n),
        .level(level_up),
        .press(press_up)
    );

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down (
        .clock(clock),
        .reset(reset),
        .pin_n(joy_down_n),
        .level(level_down),
        .press(press_down)
    );

`ifdef JOY_CONFLICT_BLOCK_EN
    // Contradictory input reads as "nothing pressed" to the paddle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            control_up   <= 1'b1;
            control_down <= 1'b1;
        end else if (!level_up && !level_down) begin
            control_up   <= 1'b1;
            control_down <= 1'b1;
        end else begin
            control_up   <= level_up;
            control_down <= level_down;
        end
    end
`else
    assign control_up   = level_up;
    assign control_down = level_down;
`endif

endmodule
